byte_serializer_lane: RTL and testbench

BYTE_SERIALIZER_LANE -- requirements
Module: byte_serializer_lane

---
 rtl/byte_serializer_lane_pkg.sv | 27 ++
 rtl/fifo_2x32.sv | 71 +++++++
 rtl/byte_serializer_lane.sv | 95 +++++++++
 tb/tb_byte_serializer_lane.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/byte_serializer_lane_pkg.sv
// Shared PHY lane constants: idle symbol, serializer state encodings and
// lane word geometry used by the striping and serializer blocks.
package byte_serializer_lane_pkg;

    // Lane word and symbol geometry
    localparam int DATA_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = DATA_W / BYTE_W;

    // COM symbol, driven on the lane whenever no data byte is valid
    localparam logic [BYTE_W-1:0] IDLE_BYTE_DEF = 8'hBC;

    // Serializer states (kept as plain constants for legacy tools)
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    // Byte index of the last byte of a word
    localparam logic [1:0] LAST_IDX = 2'd3;

    // FIFO occupancy limits
    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    typedef logic [DATA_W-1:0] lane_word_t;
    typedef logic [BYTE_W-1:0] lane_byte_t;

endpackage

// File: rtl/fifo_2x32.sv
// Two-entry in-order word buffer between the striping stage and the lane
// serializer. Push and pop on the same edge keep occupancy unchanged; a pop
// only ever removes an entry that existed before the edge.
module fifo_2x32
    import byte_serializer_lane_pkg::*;
#(
    parameter int DATA_W_P = DATA_W
)
(
    input  logic                clk_4f,
    input  logic                reset,
    input  logic                push,
    input  logic                pop,
    input  logic [DATA_W_P-1:0] din,
    output logic [DATA_W_P-1:0] head,
    output logic                full,
    output logic                empty
);

    logic [DATA_W_P-1:0] mem_p0 [2];
    logic                wr_ptr;
    logic                rd_ptr;
    logic [1:0]          occ;
    logic                do_push;
    logic                do_pop;

    // Occupancy update, held logically at 2 when full and at 0 when empty
    function automatic logic [1:0] next_occ(input logic [1:0] cur,
                                            input logic       inc,
                                            input logic       dec);
        logic [1:0] nxt;
        nxt = cur;
        case ({inc, dec})
            2'b10:   nxt = (cur == OCC_FULL)  ? cur : cur + 2'd1;
            2'b01:   nxt = (cur == OCC_EMPTY) ? cur : cur - 2'd1;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

    assign full    = (occ == OCC_FULL);
    assign empty   = (occ == OCC_EMPTY);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_p0[rd_ptr];

    // Pointer and occupancy control; entries are discarded by clearing occupancy
    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= OCC_EMPTY;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= next_occ(occ, do_push, do_pop);
        end
    end

    // Word storage, data only, no reset needed
    always_ff @(posedge clk_4f) begin
        if (do_push) begin
            mem_p0[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/byte_serializer_lane.sv
// One PHY lane: buffers 32-bit lane words from demux_striping and emits
// them MSB-first as a gapless byte stream, one byte per clk_4f cycle.
// The idle symbol fills the lane whenever no word is in flight.
module byte_serializer_lane
    import byte_serializer_lane_pkg::*;
#(
    parameter logic [BYTE_W-1:0] IDLE_BYTE = IDLE_BYTE_DEF
)
(
    input  logic              clk_4f,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic [BYTE_W-1:0] data_out,
    output logic              valid_out
);

    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic              push;
    logic              pop;
    logic              last_byte;
    logic [0:0]        state;
    logic [1:0]        idx;
    logic [DATA_W-1:0] word_p1;

    // Byte i of a word, counting from the most significant byte
    function automatic logic [BYTE_W-1:0] byte_sel(input logic [DATA_W-1:0] w,
                                                   input logic [1:0]        i);
        logic [BYTE_W-1:0] b;
        case (i)
            2'd0:    b = w[4*BYTE_W-1 -: BYTE_W];
            2'd1:    b = w[3*BYTE_W-1 -: BYTE_W];
            2'd2:    b = w[2*BYTE_W-1 -: BYTE_W];
            default: b = w[1*BYTE_W-1 -: BYTE_W];
        endcase
        return b;
    endfunction

    // Ready depends only on registered occupancy and reset, never on valid_in
    assign ready_out = ~reset & ~fifo_full;
    assign push      = valid_in & ready_out;

    // Pop when idle, or on the last byte so the next word follows without a gap
    assign last_byte = (state == ST_SEND) && (idx == LAST_IDX);
    assign pop       = ~fifo_empty & ((state == ST_IDLE) | last_byte);

    fifo_2x32 #(
        .DATA_W_P (DATA_W)
    ) u_fifo (
        .clk_4f (clk_4f),
        .reset  (reset),
        .push   (push),
        .pop    (pop),
        .din    (data_in),
        .head   (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Serializer FSM and registered lane output
    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            idx       <= 2'd0;
            valid_out <= 1'b0;
            data_out  <= IDLE_BYTE;
        end else if (pop) begin
            state     <= ST_SEND;
            idx       <= 2'd0;
            valid_out <= 1'b1;
            data_out  <= byte_sel(fifo_head, 2'd0);
        end else if ((state == ST_SEND) && !last_byte) begin
            state     <= ST_SEND;
            idx       <= idx + 2'd1;
            valid_out <= 1'b1;
            data_out  <= byte_sel(word_p1, idx + 2'd1);
        end else begin
            state     <= ST_IDLE;
            idx       <= 2'd0;
            valid_out <= 1'b0;
            data_out  <= IDLE_BYTE;
        end
    end

    // Word being serialized, captured as it leaves the FIFO
    always_ff @(posedge clk_4f) begin
        if (pop) begin
            word_p1 <= fifo_head;
        end
    end

endmodule

// File: tb/tb_byte_serializer_lane.sv
// Bench for byte_serializer_lane. The reference model keeps a schedule of
// accepted words: each word starts on the edge after acceptance or right
// after the previous word's four bytes, whichever is later.
module tb_byte_serializer_lane;

    logic        clk_4f = 1'b0;
    logic        reset  = 1'b0;
    logic [31:0] data_in = 32'd0;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic [7:0]  data_out;
    logic        valid_out;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    bit in_reset = 1'b0;
    int last_s = -1000;

    logic [31:0] sched_word [$];
    int          sched_s    [$];
    logic [31:0] stim_q     [$];

    always #5 clk_4f = ~clk_4f;

    byte_serializer_lane #(
        .IDLE_BYTE (8'hBC)
    ) dut (
        .clk_4f    (clk_4f),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_out  (data_out),
        .valid_out (valid_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    function automatic int model_occ();
        int n = 0;
        foreach (sched_s[i]) if (sched_s[i] > edge_n) n++;
        return n;
    endfunction

    task automatic model_out(output logic v, output logic [7:0] b);
        int k;
        while (sched_s.size() > 0 && sched_s[0] + 3 < edge_n) begin
            void'(sched_s.pop_front());
            void'(sched_word.pop_front());
        end
        v = 1'b0;
        b = 8'hBC;
        if (sched_s.size() > 0 && sched_s[0] <= edge_n) begin
            k = edge_n - sched_s[0];
            v = 1'b1;
            b = 8'(sched_word[0] >> (8 * (3 - k)));
        end
    endtask

    task automatic step(input logic v, input logic [31:0] d, output bit acc);
        logic       exp_rdy;
        logic       ev;
        logic [7:0] eb;
        int         s;
        @(negedge clk_4f);
        valid_in = v;
        data_in  = d;
        exp_rdy  = !in_reset && (model_occ() < 2);
        check("ready_out", ready_out, exp_rdy);
        acc = v && exp_rdy;
        @(posedge clk_4f);
        edge_n++;
        if (acc) begin
            s = (edge_n + 1 > last_s + 4) ? edge_n + 1 : last_s + 4;
            sched_s.push_back(s);
            sched_word.push_back(d);
            last_s = s;
        end
        #1;
        model_out(ev, eb);
        check("valid_out", valid_out, ev);
        check("data_out", data_out, eb);
    endtask

    task automatic idle_cycles(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, acc);
    endtask

    task automatic send_stim(input int budget);
        bit acc;
        int k = 0;
        int cyc = 0;
        while (k < stim_q.size() && cyc < budget) begin
            step(1'b1, stim_q[k], acc);
            if (acc) k++;
            cyc++;
        end
        check("stream_accepted_count", k, stim_q.size());
        valid_in = 1'b0;
    endtask

    task automatic assert_reset_now();
        in_reset = 1'b1;
        reset    = 1'b1;
        sched_s.delete();
        sched_word.delete();
        last_s = -1000;
        #1;
        check("rst_data_out", data_out, 8'hBC);
        check("rst_valid_out", valid_out, 1'b0);
        check("rst_ready_out", ready_out, 1'b0);
    endtask

    task automatic release_reset();
        @(negedge clk_4f);
        valid_in = 1'b0;
        reset    = 1'b0;
        in_reset = 1'b0;
        #1;
        check("rel_ready_out", ready_out, 1'b1);
        @(posedge clk_4f);
        edge_n++;
        #1;
        check("rel_ready_after_edge", ready_out, 1'b1);
        check("rel_valid_out", valid_out, 1'b0);
        check("rel_data_out", data_out, 8'hBC);
    endtask

    initial begin
        bit acc;
        int s_ff;
        int cyc;
        int count;

        // Power-on reset
        #1;
        assert_reset_now();
        repeat (2) @(posedge clk_4f);
        #1;
        check("por_data_out", data_out, 8'hBC);
        check("por_ready_out", ready_out, 1'b0);
        release_reset();

        // Idle lane
        idle_cycles(8);

        // Single word
        stim_q = '{32'h12345678};
        send_stim(10);
        idle_cycles(8);

        // Back-to-back words with valid held high
        stim_q = '{32'hAAAAAAAA, 32'hEEEEEEEE, 32'hCCCCCCCC, 32'h11111111};
        send_stim(60);
        idle_cycles(10);

        // Fill the FIFO, then a word that must wait for ready_out
        stim_q = '{32'h01020304, 32'hA1B2C3D4, 32'hF0E0D0C0, 32'h99999999};
        send_stim(60);
        idle_cycles(10);

        // Reset mid-word with a second word buffered
        stim_q = '{32'hFFFFFFFF, 32'h5A5A5A5A};
        send_stim(20);
        s_ff = sched_s[0];
        cyc = 0;
        while (edge_n < s_ff + 2 && cyc < 20) begin
            step(1'b0, 32'h0, acc);
            cyc++;
        end
        check("reached_byte2", edge_n, s_ff + 2);
        #2;
        assert_reset_now();
        step(1'b1, 32'h77777777, acc);
        step(1'b0, 32'h0, acc);
        release_reset();
        idle_cycles(10);

        // Random traffic
        count = 0;
        cyc = 0;
        while (count < 1000 && cyc < 20000) begin
            step(1'($urandom_range(0, 1)), $urandom, acc);
            if (acc) count++;
            cyc++;
        end
        check("random_accepted_count", count, 1000);
        idle_cycles(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
